bus_test_monitor: RTL and testbench
===================================

BUS_TEST_MONITOR -- requirements
Module: bus_test_monitor

Interface
REQ-001 Parameter ADDR_W, default 32, memory bus address width.
REQ-002 Parameter DATA_W, default 32, store data width (multiple of 8).
REQ-003 Parameter PASS_ADDR, default 100, signature address.
REQ-004 Parameter PASS_DATA, default 25, signature value meaning pass.
REQ-005 Parameter TIMEOUT_CYC, default 4700, cycles of RUN before timeout (1..2^CNT_W-1).
REQ-006 Parameter CNT_W, default 32, width of cycle and store counters.
REQ-007 Parameter TRACE_DEPTH, default 8, trace entries (power of two, >=2).
REQ-008 pclk  in  1  sole clock, rising edge.
REQ-009 RESET  in  1  asynchronous, active-low reset.
REQ-010 enable  in  1  arms monitor; sampled only in IDLE.
REQ-011 clear  in  1  synchronous return to IDLE, counters zeroed.
REQ-012 mem_addr  in  ADDR_W  store address.
REQ-013 mem_wdata  in  DATA_W  store data.
REQ-014 mem_wmask  in  DATA_W/8  byte enables; nonzero marks a store in that cycle.
REQ-015 done, pass, fail, timeout  out  1 each  sticky verdict flags.
REQ-016 cycle_count, store_count  out  CNT_W each  RUN cycles, stores seen.
REQ-017 fail_addr, fail_data  out  ADDR_W, DATA_W  capture of the failing store.
REQ-018 trace_idx  in  log2(TRACE_DEPTH); trace_addr, trace_data  out  ADDR_W, DATA_W (trace port).

Function
REQ-019 FSM states IDLE, RUN, PASS, FAIL, TIMEOUT; PASS/FAIL/TIMEOUT terminal until clear or reset.
REQ-020 IDLE -> RUN on first rising edge with enable=1; cycle_count starts at 0 in the first RUN cycle.
REQ-021 In RUN cycle_count increments by 1 per cycle, store_count by 1 per cycle with mem_wmask!=0; both freeze in terminal states and never wrap (saturate at all-ones).
REQ-022 Store with mem_addr==PASS_ADDR, mem_wmask all-ones, mem_wdata==PASS_DATA -> PASS next edge.
REQ-023 Store to PASS_ADDR with other data or partial mask -> FAIL next edge; fail_addr/fail_data capture that store (unmasked bytes zeroed).
REQ-024 Stores to any other address are counted only, no verdict.
REQ-025 cycle_count reaching TIMEOUT_CYC-1 with no verdict -> TIMEOUT next edge.
REQ-026 Simultaneous verdict store and timeout expiry: the store verdict wins.
REQ-027 done = state in {PASS, FAIL, TIMEOUT}; pass/fail/timeout are one-hot decodes of state, registered outputs.
REQ-028 clear has priority over every transition, including in the same cycle as a verdict store.
REQ-029 Stores arriving in IDLE or terminal states are ignored entirely.

Reset
REQ-030 RESET low forces state IDLE immediately, independent of pclk.
REQ-031 Reset values: all flags 0, counters 0, fail_addr/fail_data 0, trace pointer 0.
REQ-032 Reset asserted mid-RUN discards all progress; deassertion is synchronised internally (two-flop) before enable is honoured.

Configuration
REQ-033 Macro MONITOR_TRACE_EN defined: trace ring buffer of TRACE_DEPTH entries records every RUN store (addr, masked data); trace_idx=0 reads the newest store, k reads the k-th older; write pointer wraps modulo TRACE_DEPTH, oldest overwritten.
REQ-034 Macro undefined: no trace storage, trace_addr/trace_data tied to 0, all other behaviour identical.

Structure
REQ-035 Shared package holds the FSM state enumeration and the verdict encoding; parameters stay on the module.
REQ-036 One sub-module, monitor_trace_ring, holds the ring buffer and read mux; instantiated only under MONITOR_TRACE_EN.

Verification
REQ-037 enable=1, store addr 96 data 7, then addr 100 data 25 mask 4'hF -> pass=1, done=1, store_count=2, verdict one cycle after the store.
REQ-038 Store addr 100 data 24 -> fail=1, fail_addr=100, fail_data=24; a later store addr 100 data 25 leaves fail=1.
REQ-039 TIMEOUT_CYC=10, no stores -> timeout=1 exactly 10 cycles after RUN entry, cycle_count=9.
REQ-040 Verdict store (100, 25) in the same cycle as timeout expiry -> pass=1, timeout=0; same store with clear=1 -> IDLE, all flags 0.
REQ-041 RESET low for 3 ns mid-RUN, between pclk edges -> flags and counters 0 immediately; after release, enable re-arms the monitor.
REQ-042 With MONITOR_TRACE_EN, TRACE_DEPTH=4, 6 stores with data 1..6 -> trace_idx 0..3 return 6,5,4,3.

Source files
------------

// File: rtl/bus_test_monitor_pkg.sv
// Shared state and verdict encodings for the bus test monitor.
// The optional trace buffer is enabled by defining MONITOR_TRACE_EN.
package bus_test_monitor_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    VERDICT_NONE    = 2'd0,
    VERDICT_PASS    = 2'd1,
    VERDICT_FAIL    = 2'd2,
    VERDICT_TIMEOUT = 2'd3
  } verdict_t;

  function automatic logic [2:0] verdict_state(input verdict_t v);
    logic [2:0] s;
    s = ST_RUN;
    case (v)
      VERDICT_PASS:    s = ST_PASS;
      VERDICT_FAIL:    s = ST_FAIL;
      VERDICT_TIMEOUT: s = ST_TIMEOUT;
      default:         s = ST_RUN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bus_test_monitor_trace_ring.sv
// Ring buffer of recent stores; index 0 reads the newest entry.
// Instantiated by bus_test_monitor only when MONITOR_TRACE_EN is defined.
module monitor_trace_ring
  import bus_test_monitor_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     pclk,
  input  logic                     RESET,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [IDX_W-1:0]  wptr;
  logic [IDX_W-1:0]  rptr;

  always_ff @(posedge pclk or negedge RESET) begin
    if (!RESET) begin
      wptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (wr_en) begin
      addr_mem[wptr] <= wr_addr;
      data_mem[wptr] <= wr_data;
      wptr           <= wptr + IDX_W'(1);
    end
  end

  // wptr points at the next free slot, so the newest entry sits one behind it
  assign rptr    = wptr - IDX_W'(1) - rd_idx;
  assign rd_addr = addr_mem[rptr];
  assign rd_data = data_mem[rptr];

endmodule

// File: rtl/bus_test_monitor.sv
// Watches a memory store bus for a pass/fail signature write and times out otherwise.
// Optional trace ring buffer enabled by defining MONITOR_TRACE_EN.
module bus_test_monitor
  import bus_test_monitor_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PASS_ADDR   = 100,
  parameter int unsigned PASS_DATA   = 25,
  parameter int unsigned TIMEOUT_CYC = 4700,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                           pclk,
  input  logic                           RESET,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [ADDR_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W/8-1:0]            mem_wmask,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               store_count,
  output logic [ADDR_W-1:0]              fail_addr,
  output logic [DATA_W-1:0]              fail_data,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [ADDR_W-1:0]              trace_addr,
  output logic [DATA_W-1:0]              trace_data
);

  // state | meaning
  // IDLE    | waiting for enable
  // RUN     | counting cycles and stores, watching for the signature
  // PASS    | signature written with the expected value
  // FAIL    | signature address written with wrong data or partial mask
  // TIMEOUT | run length exhausted without a verdict

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] SIG_ADDR = ADDR_W'(PASS_ADDR);
  localparam logic [DATA_W-1:0] SIG_DATA = DATA_W'(PASS_DATA);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]        rst_sync;
  logic              armed;
  logic [2:0]        state;
  logic [2:0]        state_next;
  verdict_t          verdict;
  logic              is_store;
  logic              sig_hit;
  logic [DATA_W-1:0] wdata_masked;

  // Release of RESET is re-timed so enable is never sampled in the recovery window
  always_ff @(posedge pclk or negedge RESET) begin
    if (!RESET) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign armed = rst_sync[1];

  always_comb begin
    wdata_masked = '0;
    for (int b = 0; b < int'(NBYTES); b++) begin
      if (mem_wmask[b]) wdata_masked[b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  assign is_store = |mem_wmask;
  assign sig_hit  = is_store && (mem_addr == SIG_ADDR);

  // A signature store outranks a coincident timeout
  always_comb begin
    verdict = VERDICT_NONE;
    if (state == ST_RUN) begin
      if (sig_hit) begin
        if ((&mem_wmask) && (mem_wdata == SIG_DATA)) verdict = VERDICT_PASS;
        else                                         verdict = VERDICT_FAIL;
      end else if (cycle_count == TO_LAST) begin
        verdict = VERDICT_TIMEOUT;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (enable && armed) state_next = ST_RUN;
        ST_RUN:  state_next = verdict_state(verdict);
        ST_PASS, ST_FAIL, ST_TIMEOUT: state_next = state;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      store_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      state   <= state_next;
      done    <= (state_next == ST_PASS) || (state_next == ST_FAIL) ||
                 (state_next == ST_TIMEOUT);
      pass    <= (state_next == ST_PASS);
      fail    <= (state_next == ST_FAIL);
      timeout <= (state_next == ST_TIMEOUT);
      if (clear) begin
        cycle_count <= '0;
        store_count <= '0;
        fail_addr   <= '0;
        fail_data   <= '0;
      end else if (state == ST_RUN) begin
        if (is_store && (store_count != '1))
          store_count <= store_count + CNT_W'(1);
        // the cycle that produces a verdict is the last one counted
        if ((verdict == VERDICT_NONE) && (cycle_count != '1))
          cycle_count <= cycle_count + CNT_W'(1);
        if (verdict == VERDICT_FAIL) begin
          fail_addr <= mem_addr;
          fail_data <= wdata_masked;
        end
      end
    end
  end

`ifdef MONITOR_TRACE_EN
  logic trace_we;
  assign trace_we = (state == ST_RUN) && is_store && !clear;

  monitor_trace_ring #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .pclk    (pclk),
    .RESET   (RESET),
    .wr_en   (trace_we),
    .wr_addr (mem_addr),
    .wr_data (wdata_masked),
    .rd_idx  (trace_idx),
    .rd_addr (trace_addr),
    .rd_data (trace_data)
  );
`else
  logic trace_idx_unused;
  assign trace_idx_unused = ^trace_idx;
  assign trace_addr       = '0;
  assign trace_data       = '0;
`endif

endmodule

// File: tb/tb_bus_test_monitor.sv
// Self-checking bench for bus_test_monitor: vector table, corner sequences, random runs.
module tb_bus_test_monitor;

  localparam int TO = 10;

  logic        pclk = 1'b0;
  logic        RESET = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        done, pass, fail, timeout;
  logic [31:0] cycle_count, store_count, fail_addr, fail_data;
  logic [1:0]  trace_idx = '0;
  logic [31:0] trace_addr, trace_data;

  int tests_run = 0;
  int tests_failed = 0;

  bus_test_monitor #(
    .ADDR_W(32), .DATA_W(32), .PASS_ADDR(100), .PASS_DATA(25),
    .TIMEOUT_CYC(TO), .CNT_W(32), .TRACE_DEPTH(4)
  ) dut (
    .pclk(pclk), .RESET(RESET), .enable(enable), .clear(clear),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_count(cycle_count), .store_count(store_count),
    .fail_addr(fail_addr), .fail_data(fail_data),
    .trace_idx(trace_idx), .trace_addr(trace_addr), .trace_data(trace_data)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        exp_pass;
    logic        exp_fail;
    logic [31:0] exp_fdata;
    logic [31:0] exp_sc;
    logic [31:0] exp_cc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } tr_t;

  vec_t vecs[7];
  tr_t  tq[$];
  logic [31:0] r_addr[TO+2];
  logic [31:0] r_data[TO+2];
  logic [3:0]  r_mask[TO+2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_data(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic arm();
    enable = 1'b1;
    @(posedge pclk); #1;
    enable = 1'b0;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr = a; mem_wdata = d; mem_wmask = m;
    @(posedge pclk); #1;
    mem_wmask = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge pclk); #1;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #3;
    RESET = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
  endtask

  task automatic check_trace(input string name);
`ifdef MONITOR_TRACE_EN
    int n;
    n = (tq.size() < 4) ? tq.size() : 4;
    for (int k = 0; k < n; k++) begin
      trace_idx = 2'(k);
      #1;
      check({name, "_taddr"}, trace_addr, tq[tq.size()-1-k].addr);
      check({name, "_tdata"}, trace_data, tq[tq.size()-1-k].data);
    end
`else
    trace_idx = 2'd1;
    #1;
    check({name, "_taddr0"}, trace_addr, 0);
    check({name, "_tdata0"}, trace_data, 0);
`endif
  endtask

  initial begin
    vecs[0] = '{32'd100, 32'd25,         4'hF, 1'b1, 1'b0, 32'd0,          32'd1, 32'd0};
    vecs[1] = '{32'd100, 32'd24,         4'hF, 1'b0, 1'b1, 32'd24,         32'd1, 32'd0};
    vecs[2] = '{32'd100, 32'h1122_3319,  4'h3, 1'b0, 1'b1, 32'h0000_3319,  32'd1, 32'd0};
    vecs[3] = '{32'd100, 32'hAABB_CC19,  4'h8, 1'b0, 1'b1, 32'hAA00_0000,  32'd1, 32'd0};
    vecs[4] = '{32'd96,  32'd25,         4'hF, 1'b0, 1'b0, 32'd0,          32'd1, 32'd1};
    vecs[5] = '{32'd100, 32'd25,         4'h0, 1'b0, 1'b0, 32'd0,          32'd0, 32'd1};
    vecs[6] = '{32'd200, 32'd0,          4'h1, 1'b0, 1'b0, 32'd0,          32'd1, 32'd1};

    #4;
    check("rst_done", done, 0);
    check("rst_flags", {pass, fail, timeout}, 0);
    check("rst_cc", cycle_count, 0);
    check("rst_sc", store_count, 0);
    check("rst_faddr", fail_addr, 0);
    #8 RESET = 1'b1;
    repeat (3) @(posedge pclk);
    #1;

    foreach (vecs[i]) begin
      arm();
      step(vecs[i].addr, vecs[i].data, vecs[i].mask);
      check($sformatf("vec%0d_pass", i), pass, vecs[i].exp_pass);
      check($sformatf("vec%0d_fail", i), fail, vecs[i].exp_fail);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_pass | vecs[i].exp_fail);
      check($sformatf("vec%0d_sc", i), store_count, vecs[i].exp_sc);
      check($sformatf("vec%0d_cc", i), cycle_count, vecs[i].exp_cc);
      check($sformatf("vec%0d_faddr", i), fail_addr, vecs[i].exp_fail ? 32'd100 : 32'd0);
      check($sformatf("vec%0d_fdata", i), fail_data, vecs[i].exp_fdata);
      do_clear();
    end

    // basic pass, one-cycle verdict latency
    arm();
    step(32'd96, 32'd7, 4'hF);
    check("p37_pre", pass, 0);
    mem_addr = 32'd100; mem_wdata = 32'd25; mem_wmask = 4'hF;
    #2;
    check("p37_before_edge", pass, 0);
    @(posedge pclk); #1;
    mem_wmask = '0;
    check("p37_pass", pass, 1);
    check("p37_done", done, 1);
    check("p37_sc", store_count, 2);
    do_clear();

    // fail is sticky
    arm();
    step(32'd100, 32'd24, 4'hF);
    check("p38_fail", fail, 1);
    check("p38_faddr", fail_addr, 100);
    check("p38_fdata", fail_data, 24);
    step(32'd100, 32'd25, 4'hF);
    check("p38_sticky", {pass, fail}, 2'b01);
    check("p38_sc_frozen", store_count, 1);
    do_clear();

    // timeout exactly TO cycles after entry
    arm();
    repeat (TO-1) step(32'd0, 32'd0, 4'h0);
    check("p39_not_yet", timeout, 0);
    check("p39_cc9", cycle_count, TO-1);
    step(32'd0, 32'd0, 4'h0);
    check("p39_timeout", timeout, 1);
    check("p39_done", done, 1);
    check("p39_cc", cycle_count, TO-1);
    step(32'd0, 32'd0, 4'h0);
    check("p39_cc_frozen", cycle_count, TO-1);
    do_clear();

    // verdict store coincident with timeout expiry
    arm();
    repeat (TO-1) step(32'd0, 32'd0, 4'h0);
    step(32'd100, 32'd25, 4'hF);
    check("p40_pass", pass, 1);
    check("p40_no_to", timeout, 0);
    check("p40_cc", cycle_count, TO-1);
    do_clear();
    arm();
    repeat (TO-1) step(32'd0, 32'd0, 4'h0);
    clear = 1'b1;
    step(32'd100, 32'd25, 4'hF);
    clear = 1'b0;
    check("p40_clr_flags", {done, pass, fail, timeout}, 0);
    check("p40_clr_cc", cycle_count, 0);
    check("p40_clr_sc", store_count, 0);
    step(32'd0, 32'd0, 4'h0);
    check("p40_idle_cc", cycle_count, 0);

    // async reset mid-run
    arm();
    step(32'd96, 32'd1, 4'hF);
    step(32'd0, 32'd0, 4'h0);
    check("p41_pre_cc", cycle_count, 2);
    #2;
    RESET = 1'b0;
    #1;
    check("p41_cc", cycle_count, 0);
    check("p41_sc", store_count, 0);
    check("p41_flags", {done, pass, fail, timeout}, 0);
    #2;
    RESET = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    arm();
    step(32'd0, 32'd0, 4'h0);
    check("p41_rearm_cc", cycle_count, 1);
    step(32'd100, 32'd25, 4'hF);
    check("p41_rearm_pass", pass, 1);

    // randomized runs against an outcome model
    do_reset();
    tq.delete();
    for (int run = 0; run < 40; run++) begin
      int f;
      int hit;
      int sc;
      for (int i = 0; i < TO+2; i++) begin
        int r;
        r = $urandom_range(0, 9);
        r_data[i] = $urandom;
        if (r < 3) begin
          r_addr[i] = ($urandom_range(0, 1) == 1) ? 32'd100 : 32'($urandom_range(0, 500));
          r_mask[i] = 4'h0;
        end else if (r < 8) begin
          r_addr[i] = 32'($urandom_range(0, 1000));
          if (r_addr[i] == 32'd100) r_addr[i] = 32'd101;
          r_mask[i] = 4'($urandom_range(1, 15));
        end else begin
          r_addr[i] = 32'd100;
          if ($urandom_range(0, 1) == 1) r_data[i] = 32'd25;
          r_mask[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 15));
        end
      end
      hit = -1;
      for (int i = 0; i < TO; i++)
        if (hit < 0 && r_mask[i] != 0 && r_addr[i] == 32'd100) hit = i;
      f = (hit >= 0) ? hit : TO-1;
      sc = 0;
      for (int i = 0; i <= f; i++)
        if (r_mask[i] != 0) begin
          sc++;
          tq.push_back('{r_addr[i], mask_data(r_data[i], r_mask[i])});
        end

      arm();
      for (int i = 0; i < TO+2; i++) step(r_addr[i], r_data[i], r_mask[i]);
      if (hit >= 0) begin
        logic ok;
        ok = (r_mask[hit] == 4'hF) && (r_data[hit] == 32'd25);
        check($sformatf("rnd%0d_flags", run), {done, pass, fail, timeout}, {1'b1, ok, !ok, 1'b0});
        check($sformatf("rnd%0d_faddr", run), fail_addr, ok ? 32'd0 : 32'd100);
        check($sformatf("rnd%0d_fdata", run), fail_data, ok ? 32'd0 : mask_data(r_data[hit], r_mask[hit]));
      end else begin
        check($sformatf("rnd%0d_flags", run), {done, pass, fail, timeout}, 4'b1001);
      end
      check($sformatf("rnd%0d_cc", run), cycle_count, f);
      check($sformatf("rnd%0d_sc", run), store_count, sc);
      check_trace($sformatf("rnd%0d", run));
      do_clear();
    end

    // ring wrap with depth 4
    do_reset();
    tq.delete();
    arm();
    for (int i = 1; i <= 6; i++) begin
      step(32'd200 + 32'(i), 32'(i), 4'hF);
      tq.push_back('{32'd200 + 32'(i), 32'(i)});
    end
    check("p42_sc", store_count, 6);
    check_trace("p42");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
